// File: rtl/stopwatch_core.sv
// Stopwatch MM:SS time keeper with run/pause and manual adjust, BCD digit outputs.
// Latency: digits update on the first masterClk edge at which a divider rising edge is seen.
// No backpressure: divided clocks are edge-detected every cycle; optional STOPWATCH_BLINK_EN adds blink blanking.
module stopwatch_core #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       masterClk,
  input  logic       rst,
  input  logic       incClk,
  input  logic       adjClk,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
`ifdef STOPWATCH_BLINK_EN
  input  logic       blinkClk,
  output logic [1:0] blank,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  // Field limits expressed as packed BCD pairs {tens, ones}.
  localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] MAX_SEC_BCD = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       saved_run_q, saved_run_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       wrap_q, wrap_d;
  logic       inc_prev_q;
  logic       adj_prev_q;
  logic       inc_tick;
  logic       adj_tick;
  logic       eff_run;

  // One BCD pair step: the field limit rolls to 00, ones digit 9 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Divided clocks are treated as data: a tick is a sampled high with last sample low.
  assign inc_tick = incClk & ~inc_prev_q;
  assign adj_tick = adjClk & ~adj_prev_q;

  // Next-state and counting decisions; adjust mode has priority over ticks and pause.
  always_comb begin
    state_d     = state_q;
    saved_run_d = saved_run_q;
    min_d       = min_q;
    sec_d       = sec_q;
    wrap_d      = 1'b0;
    // On the cycle adjust is released the block behaves as the state it returns to.
    eff_run     = (state_q == ST_ADJUST) ? saved_run_q : (state_q == ST_RUN);

    if (adj) begin
      state_d = ST_ADJUST;
      if (state_q != ST_ADJUST) begin
        saved_run_d = (state_q == ST_RUN);
      end
      if (adj_tick) begin
        if (sel) begin
          // Seconds adjust wraps without touching minutes.
          sec_d = bcd_inc(sec_q, MAX_SEC_BCD);
        end else begin
          min_d = bcd_inc(min_q, MAX_MIN_BCD);
        end
      end
    end else if (eff_run) begin
      state_d = ST_RUN;
      if (inc_tick) begin
        sec_d = bcd_inc(sec_q, MAX_SEC_BCD);
        if (sec_q == MAX_SEC_BCD) begin
          min_d = bcd_inc(min_q, MAX_MIN_BCD);
          if (min_q == MAX_MIN_BCD) begin
            wrap_d = 1'b1;
          end
        end
      end
      // A tick coincident with pause is still counted before pausing.
      if (pause_pulse) begin
        state_d = ST_PAUSED;
      end
    end else begin
      // Paused: ticks are dropped, pause resumes.
      state_d = ST_PAUSED;
      if (pause_pulse) begin
        state_d = ST_RUN;
      end
    end
  end

  // State, time and edge-detect registers with synchronous reset.
  always_ff @(posedge masterClk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      saved_run_q <= 1'b1;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      wrap_q      <= 1'b0;
      inc_prev_q  <= 1'b0;
      adj_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_run_q <= saved_run_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      wrap_q      <= wrap_d;
      inc_prev_q  <= incClk;
      adj_prev_q  <= adjClk;
    end
  end

`ifdef STOPWATCH_BLINK_EN
  logic blink_q;

  // Sampled blink square wave drives blanking of the field under adjustment.
  always_ff @(posedge masterClk) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blinkClk;
    end
  end

  // Only the selected field blinks, and only while adjusting.
  always_comb begin
    blank = 2'b00;
    if (state_q == ST_ADJUST) begin
      if (sel) begin
        blank[0] = blink_q;
      end else begin
        blank[1] = blink_q;
      end
    end
  end
`endif

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
  assign running  = (state_q == ST_RUN);
  assign wrap     = wrap_q;

endmodule
